// File: rtl/data_ram_arbiter.sv
// Two-requester (core, IO) arbiter for the single-port data RAM; one transaction in flight at a time.
// Latency: write completes at the grant edge; read data and rvalid appear RD_LAT+1 cycles after the grant.
// Backpressure: gnt is withheld while a read is waiting on the RAM; requesters hold req until gnt.
// Optional build macro RR_ARB_EN: round-robin arbitration when defined, fixed core-over-IO priority otherwise.
module data_ram_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [31:0]       core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              io_req,
    input  logic              io_we,
    input  logic [31:0]       io_addr,
    input  logic [DATA_W-1:0] io_wdata,
    output logic              io_gnt,
    output logic              io_rvalid,
    output logic [DATA_W-1:0] io_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_DONE = 2'd2;

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic              owner;      // 0 = core, 1 = io
    logic [ADDR_W-1:0] addr_q;     // last granted word address
    logic              arb_ok;
    logic              pick_io;
    logic              grant;
    logic              win_we;
    logic [31:0]       win_addr;

    // Byte-offset and high address bits carry no meaning for the RAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{core_addr[31:ADDR_W+2], core_addr[1:0],
                                io_addr[31:ADDR_W+2], io_addr[1:0]};

    // Arbitration is open in IDLE and RD_DONE; a reset cycle never grants.
    assign arb_ok = !rst && (state != RD_WAIT);

`ifdef RR_ARB_EN
    logic rr_ptr;   // requester that wins the next collision: 0 = core, 1 = io

    // Point at the loser of every grant so collisions alternate.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (grant) begin
            rr_ptr <= ~pick_io;
        end
    end

    assign pick_io = io_req && (!core_req || rr_ptr);
`else
    assign pick_io = io_req && !core_req;
`endif

    assign grant    = arb_ok && (core_req || io_req);
    assign core_gnt = grant && !pick_io;
    assign io_gnt   = grant && pick_io;

    assign win_we   = pick_io ? io_we    : core_we;
    assign win_addr = pick_io ? io_addr  : core_addr;

    // RAM side: the winner drives the macro directly in the grant cycle, otherwise the last address is held.
    assign mem_we   = grant && win_we;
    assign mem_addr = grant ? win_addr[ADDR_W+1:2] : addr_q;
    assign mem_din  = pick_io ? io_wdata : core_wdata;

    assign busy = (state != IDLE);

    // Transaction FSM: grant, count down the RAM latency, deliver read data to the issuer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 3'd0;
            owner       <= 1'b0;
            addr_q      <= '0;
            core_rvalid <= 1'b0;
            io_rvalid   <= 1'b0;
            core_rdata  <= '0;
            io_rdata    <= '0;
        end else begin
            core_rvalid <= 1'b0;
            io_rvalid   <= 1'b0;
            case (state)
                RD_WAIT: begin
                    if (cnt == 3'd0) begin
                        state <= RD_DONE;
                        if (owner) begin
                            io_rdata  <= mem_dout;
                            io_rvalid <= 1'b1;
                        end else begin
                            core_rdata  <= mem_dout;
                            core_rvalid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    // IDLE and RD_DONE arbitrate identically.
                    state <= IDLE;
                    if (grant) begin
                        addr_q <= win_addr[ADDR_W+1:2];
                        if (!win_we) begin
                            state <= RD_WAIT;
                            owner <= pick_io;
                            cnt   <= 3'(RD_LAT - 1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single-port data RAM (block-memory macro, 14-bit word address, 32-bit data, registered read output) between two requesters: the core MEM stage and the IO/loader path.
- Accepts one transaction at a time. Writes complete in one cycle. Reads wait a fixed latency and then return data with a one-cycle valid pulse to the requester that issued the read.
- Sits between the core/IO logic and the RAM macro. It replaces ad-hoc address muxing and ready counting.

Parameters:
- ADDR_W, 14, RAM word-address width; byte-address bits [ADDR_W+1:2] are used.
- DATA_W, 32, data width.
- RD_LAT, 2, RAM read latency in cycles from the address edge to valid mem_dout; legal range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- core_req  in  1  core transaction request; held until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  32  byte address.
- core_wdata  in  DATA_W  write data.
- core_gnt  out  1  one-cycle accept pulse (combinational).
- core_rvalid  out  1  one-cycle read-data-valid pulse (registered).
- core_rdata  out  DATA_W  read data (registered; holds last value).
- io_req, io_we, io_addr, io_wdata, io_gnt, io_rvalid, io_rdata: same as the core_* ports, for the IO requester.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM word address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - Clears to: state IDLE, owner = core, rr_ptr = core, cnt 0.
  - Both rvalid outputs 0, both rdata outputs 0, busy 0.
  - Reset mid-read aborts the read: no rvalid is ever produced for it.
- FSM states: IDLE, RD_WAIT, RD_DONE.
- IDLE:
  - If a request is present, select a winner. The winner's gnt is asserted in the same cycle.
  - Drive mem_addr = winner_addr[ADDR_W+1:2], mem_din = winner_wdata, mem_we = winner_we.
  - Write: the transaction completes at the edge. Stay in IDLE, so a new request can be granted in the next cycle (one write per cycle).
  - Read: latch the address and owner, set cnt = RD_LAT-1, go to RD_WAIT.
  - With no request: mem_we = 0, and mem_addr holds the last address.
- RD_WAIT:
  - mem_addr held at the latched address, mem_we = 0, both gnt = 0.
  - cnt decrements each cycle. When cnt == 0, capture mem_dout into owner_rdata and go to RD_DONE.
- RD_DONE:
  - owner_rvalid = 1 for exactly this cycle.
  - Behaves as IDLE for arbitration, so a new request may be granted here.
  - Next state follows the IDLE rules.
- Timing:
  - Read accepted in cycle 0; rvalid is high in cycle RD_LAT+1 (cycle 3 by default).
  - Back-to-back reads: one per RD_LAT+1 cycles.
- The non-owner's rvalid never asserts. Its rdata is not updated.
- Address bits [1:0] and bits above ADDR_W+1 are ignored; no alignment error is raised.
- Requesters must hold req, we, addr and wdata stable until gnt. Deasserting req before gnt withdraws the request with no side effect.
- gnt is at most one-hot. It is never asserted in RD_WAIT. Only one transaction is outstanding at a time.
- rr_ptr updates only on a grant: it points to the requester that was not granted.

Optional Feature:
- Macro RR_ARB_EN.
- Defined: round-robin arbitration. When both requesters are active, the requester named by rr_ptr wins. A single active requester always wins.
- Undefined: fixed priority, core over IO. rr_ptr is not implemented, and IO can starve while core_req stays high.

Test Plan:
- Core write, then read: core_we=1, addr 0x0000_0010, wdata 0xDEADBEEF.
  - Expect core_gnt in the same cycle, mem_we=1, mem_addr=4.
  - Then a read of 0x10 gives core_rvalid 3 cycles after gnt, with core_rdata=0xDEADBEEF; io_rvalid stays 0.
- Collision, with and without RR_ARB_EN: core and IO both issue reads, held continuously.
  - Without the macro: core is granted every time.
  - With the macro: grants alternate core, io, core. Each rvalid goes only to its issuer.
- Request during a read: io_req write arrives 1 cycle after a core read is granted.
  - Expect io_gnt=0 and mem_we=0 through RD_WAIT.
  - io_gnt asserts in the RD_DONE cycle, the same cycle core_rvalid=1.
- Write throughput: 4 consecutive core writes to addrs 0x0, 0x4, 0x8, 0xC.
  - Expect 4 gnts in 4 consecutive cycles, with mem_addr = 0, 1, 2, 3.
- Reset mid-read: rst=1 in the cycle after a core read is granted.
  - Expect busy=0, no core_rvalid afterwards, core_rdata=0.
  - A new request in the cycle after reset is granted.
- Address masking: core read at 0x0001_0007.
  - Expect mem_addr = 14'h0001 with ADDR_W=14.
